sig_check: RTL and testbench

SIG_CHECK -- requirements
Module: sig_check

---
 rtl/sig_check_pkg.sv | 16 +
 rtl/sig_check.sv | 130 +++++++++++++
 tb/tb_sig_check.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/sig_check_pkg.sv
// Shared definitions for the signature-check sequencer: state encoding and
// default sizing for the reset window and run-cycle counter.
package sig_check_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RESET = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } sc_state_e;

  localparam int RST_CYCLES_DEF = 4;
  localparam int CNT_W_DEF      = 16;
  localparam int SIG_W          = 16;

endpackage

// File: rtl/sig_check.sv
// Sequences one self-test session: holds the core in reset, lets it run for a
// programmed number of cycles, then captures and compares the signature.
module sig_check
  import sig_check_pkg::*;
#(
  parameter int RST_CYCLES = RST_CYCLES_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] run_cycles,
  input  logic [15:0]      golden_sig,
  input  logic [15:0]      sig_in,
  output logic             dut_rst,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [15:0]      sig_captured
);

  localparam logic [3:0] RST_LAST = 4'(RST_CYCLES - 1);

  sc_state_e        state_q, state_d;
  logic [3:0]       rcnt_q, rcnt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] rc_q, rc_d;
  logic [15:0]      gold_q, gold_d;
  logic [15:0]      sig_q, sig_d;
  logic             dut_rst_q, dut_rst_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      rcnt_q    <= '0;
      cnt_q     <= '0;
      rc_q      <= '0;
      gold_q    <= '0;
      sig_q     <= '0;
      dut_rst_q <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rcnt_q    <= rcnt_d;
      cnt_q     <= cnt_d;
      rc_q      <= rc_d;
      gold_q    <= gold_d;
      sig_q     <= sig_d;
      dut_rst_q <= dut_rst_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
    end
  end

  // Outputs are computed one cycle ahead so every port comes straight from a flop.
  always_comb begin
    state_d   = state_q;
    rcnt_d    = rcnt_q;
    cnt_d     = cnt_q;
    rc_d      = rc_q;
    gold_d    = gold_q;
    sig_d     = sig_q;
    dut_rst_d = dut_rst_q;
    busy_d    = busy_q;
    done_d    = done_q;
    pass_d    = pass_q;

    if (abort) begin
      state_d   = ST_IDLE;
      rcnt_d    = '0;
      cnt_d     = '0;
      dut_rst_d = 1'b1;
      busy_d    = 1'b0;
      done_d    = 1'b0;
      pass_d    = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_d   = ST_RESET;
            rc_d      = run_cycles;
            gold_d    = golden_sig;
            rcnt_d    = '0;
            dut_rst_d = 1'b1;
            busy_d    = 1'b1;
            done_d    = 1'b0;
            pass_d    = 1'b0;
          end
        end
        ST_RESET: begin
          if (rcnt_q == RST_LAST) begin
            state_d   = ST_RUN;
            cnt_d     = '0;
            dut_rst_d = 1'b0;
          end else begin
            rcnt_d = rcnt_q + 4'd1;
          end
        end
        ST_RUN: begin
          // Compare before incrementing so the all-ones count ends without wrapping.
          if (cnt_q == rc_q) begin
            state_d   = ST_DONE;
            sig_d     = sig_in;
            pass_d    = (sig_in == gold_q);
            dut_rst_d = 1'b1;
            busy_d    = 1'b0;
            done_d    = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign dut_rst      = dut_rst_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign pass         = pass_q;
  assign sig_captured = sig_q;

endmodule

// File: tb/tb_sig_check.sv
// Directed bench for sig_check; an idle compactor is modelled as a register
// that loads 1 under reset and shifts left once per running cycle.
module tb_sig_check;

  localparam int RST_CYC = 4;
  localparam int CW      = 10;
  localparam int LIMIT   = 3000;

  logic          clk = 1'b0;
  logic          rst;
  logic          start, abort;
  logic [CW-1:0] run_cycles;
  logic [15:0]   golden_sig, sig_in;
  logic          dut_rst, busy, done, pass;
  logic [15:0]   sig_captured;

  int n_cmp = 0;
  int n_bad = 0;
  int lat;
  logic seen_done;

  sig_check #(.RST_CYCLES(RST_CYC), .CNT_W(CW)) u_dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .run_cycles(run_cycles), .golden_sig(golden_sig), .sig_in(sig_in),
    .dut_rst(dut_rst), .busy(busy), .done(done), .pass(pass),
    .sig_captured(sig_captured)
  );

  always #5 clk = ~clk;

  // Idle compactor: post-reset value 1, one shift per update.
  logic [15:0] comp_q;
  always @(posedge clk) begin
    if (dut_rst) comp_q <= 16'h0001;
    else         comp_q <= comp_q << 1;
  end
  assign sig_in = comp_q;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  // Run one session; lat = clock edges from the start edge to done.
  task automatic session(input logic [CW-1:0] rc, input logic [15:0] gold,
                         input int restart_at, output int lat_o);
    int n;
    @(negedge clk);
    run_cycles = rc;
    golden_sig = gold;
    start      = 1'b1;
    @(negedge clk);
    start      = 1'b0;
    run_cycles = ~rc;
    golden_sig = ~gold;
    n = 1;
    while (!done && n < LIMIT) begin
      if (n == restart_at) start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n++;
    end
    if (!done) chk("timeout", 32'd0, 32'd1);
    lat_o = n - 1;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    run_cycles = '0; golden_sig = '0;
    repeat (2) @(negedge clk);
    chk("rst_dut_rst", dut_rst, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_sig", sig_captured, 16'h0000);
    rst = 1'b0;

    // Zero-length run captures the post-reset signature.
    session('0, 16'h0001, -1, lat);
    chk("rc0_lat", lat, RST_CYC + 1);
    chk("rc0_sig", sig_captured, 16'h0001);
    chk("rc0_pass", pass, 1);
    chk("rc0_busy", busy, 0);
    chk("rc0_dut_rst", dut_rst, 1);

    session(10'd1, 16'h0002, -1, lat);
    chk("rc1_lat", lat, RST_CYC + 2);
    chk("rc1_sig", sig_captured, 16'h0002);
    chk("rc1_pass", pass, 1);

    session(10'd1, 16'h0003, -1, lat);
    chk("rc1_bad_sig", sig_captured, 16'h0002);
    chk("rc1_bad_pass", pass, 0);

    session(10'd16, 16'h0000, -1, lat);
    chk("rc16_lat", lat, RST_CYC + 1 + 16);
    chk("rc16_sig", sig_captured, 16'h0000);
    chk("rc16_pass", pass, 1);

    // Second start lands while running and must be ignored.
    session(10'd8, 16'h0100, 8, lat);
    chk("restart_lat", lat, RST_CYC + 1 + 8);
    chk("restart_sig", sig_captured, 16'h0100);
    chk("restart_pass", pass, 1);

    // Abort and start together while done: abort wins.
    @(negedge clk);
    abort = 1'b1; start = 1'b1;
    @(negedge clk);
    abort = 1'b0; start = 1'b0;
    chk("abort_start_done", done, 0);
    chk("abort_start_busy", busy, 0);
    chk("abort_start_pass", pass, 0);
    chk("abort_start_sig", sig_captured, 16'h0100);

    // Abort mid-run.
    @(negedge clk);
    run_cycles = 10'd20; golden_sig = 16'h0000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    chk("run_dut_rst", dut_rst, 0);
    chk("run_busy", busy, 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_pass", pass, 0);
    chk("abort_dut_rst", dut_rst, 1);
    chk("abort_sig", sig_captured, 16'h0100);
    seen_done = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (done) seen_done = 1'b1;
    end
    chk("abort_no_done", seen_done, 0);

    session(10'd2, 16'h0004, -1, lat);
    chk("post_abort_lat", lat, RST_CYC + 3);
    chk("post_abort_sig", sig_captured, 16'h0004);
    chk("post_abort_pass", pass, 1);

    // Asynchronous reset during the reset window.
    @(negedge clk);
    run_cycles = 10'd3; golden_sig = 16'h0008; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("mid_reset_busy", busy, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_dut_rst", dut_rst, 1);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_pass", pass, 0);
    chk("arst_sig", sig_captured, 16'h0000);
    @(negedge clk);
    rst = 1'b0;
    seen_done = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (done || busy) seen_done = 1'b1;
    end
    chk("arst_no_done", seen_done, 0);

    // Largest count must terminate without wrapping.
    session('1, 16'h0000, -1, lat);
    chk("max_lat", lat, RST_CYC + 1 + (2**CW - 1));
    chk("max_sig", sig_captured, 16'h0000);
    chk("max_pass", pass, 1);
    chk("max_done", done, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
